// File: rtl/ps2_key_input.sv
// PS/2 keyboard front end: oversampled receiver, E0/F0 sequence decoder, held-direction vector, event FIFO.
// evt_valid rises 2 clk after the stop bit is framed; when the FIFO is full and not popping, new events are dropped and fifo_ovf pulses.
`timescale 1ns/1ps
module ps2_key_input #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [3:0] touch_dir,
    output logic [3:0] dir,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       frame_err,
    output logic       fifo_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Bit 0 carries ps2_clk, bit 1 carries ps2_dat; both idle high.
    logic [1:0]    sync1_q, sync2_q, filt_q, flip;
    logic [FW-1:0] fcnt_q [2];

    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          fall, dat, err, done;

    logic          done_q, ext_q, ext_d, brk_q, brk_d, key_evt;
    logic [3:0]    held_q, held_d, dir_hit, dir_q;
    logic          frame_err_q, fifo_ovf_q;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          full, pop, wr, ovf;
    logic [9:0]    head;

    always_comb begin
        flip = '0;
        for (int i = 0; i < 2; i++) begin
            flip[i] = (sync2_q[i] != filt_q[i]) && (fcnt_q[i] == FW'(FILTER_LEN - 1));
        end
    end

    assign fall = flip[0] & filt_q[0];
    assign dat  = filt_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            sync1_q <= {ps2_dat, ps2_clk};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i] || flip[i]) fcnt_q[i] <= '0;
                else fcnt_q[i] <= fcnt_q[i] + FW'(1);
                if (flip[i]) filt_q[i] <= sync2_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = '0;
        err      = 1'b0;
        done     = 1'b0;
        if (state_q != S_IDLE) begin
            tmo_d = fall ? '0 : tmo_q + TW'(1);
            if (!fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
        end
        if (fall) begin
            case (state_q)
                S_IDLE: if (!dat) begin
                    state_d  = S_DATA;
                    bitcnt_d = '0;
                end
                S_DATA: begin
                    shift_d  = {dat, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (dat && (^{shift_q, par_q})) done = 1'b1;
                    else err = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // shift_q still holds the received byte during the decode cycle.
    assign dir_hit[0] = ext_q ? (shift_q == 8'h75) : (shift_q == 8'h1D);
    assign dir_hit[1] = ext_q ? (shift_q == 8'h72) : (shift_q == 8'h1B);
    assign dir_hit[2] = ext_q ? (shift_q == 8'h6B) : (shift_q == 8'h1C);
    assign dir_hit[3] = ext_q ? (shift_q == 8'h74) : (shift_q == 8'h23);

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        held_d  = held_q;
        key_evt = 1'b0;
        if (err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (done_q) begin
            if (shift_q == 8'hE0) ext_d = 1'b1;
            else if (shift_q == 8'hF0) brk_d = 1'b1;
            else begin
                key_evt = 1'b1;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                for (int i = 0; i < 4; i++) if (dir_hit[i]) held_d[i] = ~brk_q;
            end
        end
    end

    assign pop  = evt_valid & evt_ready;
    assign full = (cnt_q == CW'(FIFO_DEPTH));
    assign wr   = key_evt & (~full | pop);
    assign ovf  = key_evt & full & ~pop;
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= {ext_q, brk_q, shift_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= '0;
            dir_q       <= '0;
            frame_err_q <= 1'b0;
            fifo_ovf_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            done_q      <= done;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            held_q      <= held_d;
            dir_q       <= held_d | touch_dir;
            frame_err_q <= err;
            fifo_ovf_q  <= ovf;
            if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(wr) - CW'(pop);
        end
    end

    assign evt_valid = (cnt_q != '0);
    assign {evt_ext, evt_break, evt_code} = evt_valid ? head : 10'd0;
    assign dir       = dir_q;
    assign frame_err = frame_err_q;
    assign fifo_ovf  = fifo_ovf_q;

endmodule
